// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS inter-stage registers: control-bundle
// widths per stage boundary, field offsets and NOP (bubble) encodings.
package mips_pipe_pkg;

    // Control-bundle widths per stage boundary
    localparam int unsigned CTRL_W_IDEX  = 24;
    localparam int unsigned CTRL_W_EXMEM = 8;
    localparam int unsigned CTRL_W_MEMWB = 4;

    // ID/EX control-bundle field offsets (LSB position) and widths
    localparam int unsigned CF_REGWRITE  = 0;
    localparam int unsigned CF_MEMREAD   = 1;
    localparam int unsigned CF_MEMWRITE  = 2;
    localparam int unsigned CF_MEMTOREG  = 3;   // 2 bits
    localparam int unsigned CF_ALUFUN    = 5;   // 6 bits
    localparam int unsigned CF_PCSRC     = 11;  // 3 bits
    localparam int unsigned CF_REGDST    = 14;  // 2 bits
    localparam int unsigned CF_ALUSRC1   = 16;
    localparam int unsigned CF_ALUSRC2   = 17;
    localparam int unsigned CF_SIGN      = 18;

    localparam int unsigned CF_MEMTOREG_W = 2;
    localparam int unsigned CF_ALUFUN_W   = 6;
    localparam int unsigned CF_PCSRC_W    = 3;
    localparam int unsigned CF_REGDST_W   = 2;

    // NOP control encodings: no register write, no memory access
    localparam logic [CTRL_W_IDEX-1:0]  CTRL_BUBBLE_IDEX  = '0;
    localparam logic [CTRL_W_EXMEM-1:0] CTRL_BUBBLE_EXMEM = '0;
    localparam logic [CTRL_W_MEMWB-1:0] CTRL_BUBBLE_MEMWB = '0;

    // Occupancy of the two-entry stage, encoded as {s_v, m_v}
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b11
    } pipe_state_t;

endpackage

// File: rtl/mips_pipe_slot.sv
// Single pipeline entry {valid, data, ctrl} with load and clear.
// Clear dominates load; clearing leaves the payload registers stale.
module mips_pipe_slot #(
    parameter int unsigned          DATA_W   = 128,
    parameter int unsigned          CTRL_W   = 24,
    parameter logic [CTRL_W-1:0]    CTRL_RST = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] d_data,
    input  logic [CTRL_W-1:0] d_ctrl,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl
);

    // Entry register: async reset, clear drops validity, load captures payload
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
            ctrl  <= CTRL_RST;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= d_data;
            ctrl  <= d_ctrl;
        end
    end

endmodule

// File: rtl/mips_pipe_stage.sv
// Generic MIPS inter-stage register: valid/ready handshake with a 2-entry
// skid buffer, bubble insertion, synchronous flush and a saturating
// stall-cycle counter.
module mips_pipe_stage
    import mips_pipe_pkg::*;
#(
    parameter int unsigned       DATA_W      = 128,
    parameter int unsigned       CTRL_W      = 24,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
    parameter int unsigned       CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              bubble,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              m_v, s_v;
    logic [DATA_W-1:0] m_data, s_data;
    logic [CTRL_W-1:0] m_ctrl, s_ctrl;

    logic              acc, pop, stall;
    logic [CTRL_W-1:0] cap_ctrl;
    pipe_state_t       cur;

    logic              m_load, m_clr, m_from_skid;
    logic              s_load, s_clr, s_nxt;
    logic [DATA_W-1:0] m_d_data;
    logic [CTRL_W-1:0] m_d_ctrl;

    assign acc      = in_valid && in_ready && !flush;
    assign pop      = m_v && out_ready;
    assign stall    = in_valid && !in_ready && !flush;
    assign cap_ctrl = bubble ? CTRL_BUBBLE : in_ctrl;

    assign out_valid = m_v;
    assign out_data  = m_data;
    assign out_ctrl  = m_v ? m_ctrl : CTRL_BUBBLE;

    // Next-state decode; the state itself lives in the slot valid bits
    always_comb begin
        cur         = pipe_state_t'({s_v, m_v});
        m_load      = 1'b0;
        m_clr       = 1'b0;
        m_from_skid = 1'b0;
        s_load      = 1'b0;
        s_clr       = 1'b0;
        case (cur)
            ONE: begin
                if (acc && pop) begin
                    m_load = 1'b1;
                end else if (acc) begin
                    s_load = 1'b1;
                end else if (pop) begin
                    m_clr = 1'b1;
                end
            end
            TWO: begin
                if (pop) begin
                    m_load      = 1'b1;
                    m_from_skid = 1'b1;
                    s_clr       = 1'b1;
                end
            end
            default: begin
                if (acc) begin
                    m_load = 1'b1;
                end
            end
        endcase
        if (flush) begin
            m_load = 1'b0;
            s_load = 1'b0;
            m_clr  = 1'b1;
            s_clr  = 1'b1;
        end
        m_d_data = m_from_skid ? s_data : in_data;
        m_d_ctrl = m_from_skid ? s_ctrl : cap_ctrl;
        s_nxt    = s_clr ? 1'b0 : (s_load ? 1'b1 : s_v);
    end

    mips_pipe_slot #(
        .DATA_W   (DATA_W),
        .CTRL_W   (CTRL_W),
        .CTRL_RST (CTRL_BUBBLE)
    ) u_main (
        .clk    (clk),
        .reset  (reset),
        .load   (m_load),
        .clear  (m_clr),
        .d_data (m_d_data),
        .d_ctrl (m_d_ctrl),
        .valid  (m_v),
        .data   (m_data),
        .ctrl   (m_ctrl)
    );

    mips_pipe_slot #(
        .DATA_W   (DATA_W),
        .CTRL_W   (CTRL_W),
        .CTRL_RST (CTRL_BUBBLE)
    ) u_skid (
        .clk    (clk),
        .reset  (reset),
        .load   (s_load),
        .clear  (s_clr),
        .d_data (in_data),
        .d_ctrl (cap_ctrl),
        .valid  (s_v),
        .data   (s_data),
        .ctrl   (s_ctrl)
    );

    // Registered ready: tracks the skid occupancy of the next cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_ready <= 1'b1;
        end else begin
            in_ready <= !s_nxt;
        end
    end

    // Saturating stall-cycle counter, cleared only by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: doc/mips_pipe_stage.md
Name: mips_pipe_stage

Overview:
- Generic, parametrised inter-stage register for the pipelined MIPS core. It supersedes the fixed ID/EX-style register.
- Carries a data bundle (PCs, operands, immediates) and a control bundle (RegWrite, MemWrite, ALUFun, ...) with a valid/ready handshake.
- A 2-entry skid buffer lets backpressure be fully registered.
- Supports bubble insertion (control squashed, data kept), synchronous flush, and a saturating stall-cycle counter for performance analysis.

Parameters:
- DATA_W, 128, width of the data bundle (payload copied verbatim).
- CTRL_W, 24, width of the control bundle.
- CTRL_BUBBLE, {CTRL_W{1'b0}}, control value that makes an entry architecturally inert (NOP).
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  reset, asynchronous, active-high.
- in_valid  in  1  upstream stage presents an entry.
- in_ready  out  1  block can accept an entry this cycle; registered.
- in_data  in  DATA_W  upstream data bundle.
- in_ctrl  in  CTRL_W  upstream control bundle.
- bubble  in  1  squash the control of the entry accepted this cycle (hazard-unit load-use bubble).
- flush  in  1  discard all held entries and any entry offered this cycle (branch/jump redirect).
- out_valid  out  1  out_data/out_ctrl hold a live entry.
- out_ready  in  1  downstream stage consumes the entry.
- out_data  out  DATA_W  head-entry data.
- out_ctrl  out  CTRL_W  head-entry control; CTRL_BUBBLE when not valid.
- stall_cnt  out  CNT_W  saturating count of cycles with in_valid && !in_ready.

Behaviour:
- Storage:
  - main entry {m_v, m_data, m_ctrl} drives the outputs.
  - skid entry {s_v, s_data, s_ctrl}.
  - States: EMPTY (m_v=0, s_v=0), ONE (m_v=1, s_v=0), TWO (m_v=1, s_v=1). The state is m_v/s_v, not a separate register.
- Events:
  - acc = in_valid && in_ready && !flush.
  - pop = out_valid && out_ready.
- Captured control is (bubble ? CTRL_BUBBLE : in_ctrl). Data is always captured as in_data.
- Bubbled entries are still valid entries: they occupy a slot and flow downstream.
- in_ready = !s_v, registered. out_valid = m_v. out_data = m_data. out_ctrl = m_v ? m_ctrl : CTRL_BUBBLE.
- Transitions (next state):
  - EMPTY: acc -> ONE (main <= input).
  - ONE:
    - acc && pop -> ONE (main <= input).
    - acc && !pop -> TWO (skid <= input).
    - !acc && pop -> EMPTY.
    - else hold.
  - TWO: in_ready=0, so acc is impossible.
    - pop -> ONE (main <= skid, s_v <= 0).
    - else hold.
- Latency: an entry accepted in cycle N is visible on out_* in cycle N+1 (EMPTY/ONE with pop).
- Ordering is strictly FIFO; no entry is ever duplicated or reordered.
- Flush:
  - Synchronous; highest priority after reset.
  - Next cycle: m_v=0, s_v=0, in_ready=1, out_ctrl=CTRL_BUBBLE.
  - The input offered in the flush cycle is dropped.
  - A pop in the flush cycle is still a legal consumption; downstream saw out_valid=1.
  - Data registers may keep stale values; only valid bits and the control output matter.
- bubble && flush together: flush wins, nothing captured.
- bubble with !in_valid or !in_ready: no effect.
- stall_cnt:
  - Increments by 1 each cycle in_valid && !in_ready && !flush.
  - Saturates at 2^CNT_W-1; never wraps.
  - Cleared only by reset.
- Reset (async, any state, mid-transfer included):
  - m_v=s_v=0, in_ready=1, out_valid=0.
  - out_data=0, out_ctrl=CTRL_BUBBLE, stall_cnt=0.
  - Skid contents are discarded.
- Continuous flow: with out_ready=1 held, throughput is 1 entry/cycle and the skid is never used.

Decomposition:
- Shared package mips_pipe_pkg:
  - CTRL_W constants per stage boundary (ID/EX, EX/MEM, MEM/WB).
  - Control-bundle field offsets (RegWrite, MemRead, MemWrite, MemtoReg, ALUFun, PCSrc, RegDst, ALUSrc1/2, Sign).
  - Per-stage CTRL_BUBBLE constants.
- One natural sub-module, mips_pipe_slot: a single {valid, data, ctrl} register with load/clear. It is instantiated twice (main, skid).
- Next-state logic and the counter stay in the top.

Test Plan:
1. Reset mid-TWO:
   - Stimulus: fill with A=0x11, B=0x22 (out_ready=0), then assert reset for one cycle.
   - Required: out_valid=0, in_ready=1, out_ctrl=CTRL_BUBBLE, stall_cnt=0. After release, accept C=0x33 and see 0x33 out next cycle; B never appears.
2. Streaming:
   - Stimulus: out_ready=1; send data 1..8 back-to-back with ctrl=0x5A.
   - Required: out_data 1..8 in consecutive cycles at 1-cycle latency, in_ready stays 1, stall_cnt=0.
3. Backpressure/skid:
   - Stimulus: send A=0xA, B=0xB, C=0xC with out_ready=0.
   - Required: A held on out, B in skid, in_ready=0 after B, C held by upstream, stall_cnt increments each cycle. When out_ready=1, output sequence is A, B, C with no gap after A.
4. Bubble:
   - Stimulus: accept D=0xD0 with in_ctrl=0xFFFFFF and bubble=1.
   - Required: out_valid=1, out_data=0xD0, out_ctrl=CTRL_BUBBLE.
5. Flush:
   - Stimulus: state TWO (E, F), then flush=1 while in_valid=1 with G.
   - Required next cycle: out_valid=0, in_ready=1, out_ctrl=CTRL_BUBBLE; E, F and G are never output.
   - Also: flush && bubble in the same cycle captures nothing.
6. Counter saturation:
   - Stimulus: CNT_W=4; hold in_valid=1, out_ready=0 for 30 cycles.
   - Required: stall_cnt reaches 15 and stays at 15.
